game_sprite_motion_engine: RTL and testbench



---
 rtl/game_sprite_pkg.sv | 20 ++
 rtl/game_frame_tick.sv | 38 +++
 rtl/game_sprite_motion_engine.sv | 103 ++++++++++
 tb/tb_game_sprite_motion_engine.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_sprite_pkg.sv
// Shared types and screen/sprite size defaults for the sprite motion engines.
// Defaults match game_config so every sprite instance agrees on the screen box.
package game_sprite_pkg;
   localparam int DEF_SCREEN_W = 640;
   localparam int DEF_SCREEN_H = 480;
   localparam int DEF_X_W      = 10;
   localparam int DEF_Y_W      = 10;
   localparam int DEF_SPRITE_W = 8;
   localparam int DEF_SPRITE_H = 8;
   localparam int DEF_DXY_W    = 4;

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      MOVING  = 2'd1,
      EXITED  = 2'd2
   } sprite_state_t;

   typedef logic [DEF_X_W-1:0] coord_x_t;
   typedef logic [DEF_Y_W-1:0] coord_y_t;
endpackage

// File: rtl/game_frame_tick.sv
// Detects vsync rising edges and divides them by FRAME_DIV into step pulses.
// The divider only advances while enabled; clear restarts it from zero.
module game_frame_tick #(
   parameter int FRAME_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic vsync,
   input  logic enable,
   input  logic clear,
   output logic step
);
   localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

   logic             vsync_prev;
   logic [CNT_W-1:0] count;
   logic             tick;
   logic             at_last;

   assign tick    = vsync & ~vsync_prev;
   assign at_last = (count == CNT_LAST);
   assign step    = tick & enable & at_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_prev <= 1'b0;
         count      <= '0;
      end else begin
         vsync_prev <= vsync;
         if (clear) begin
            count <= '0;
         end else if (tick && enable) begin
            count <= at_last ? '0 : count + 1'b1;
         end
      end
   end
endmodule

// File: rtl/game_sprite_motion_engine.sv
// Per-sprite position/velocity engine: applies dx/dy once every FRAME_DIV frames
// while moving, and freezes the sprite once it leaves the screen.
module game_sprite_motion_engine
   import game_sprite_pkg::*;
#(
   parameter int SCREEN_W  = DEF_SCREEN_W,
   parameter int SCREEN_H  = DEF_SCREEN_H,
   parameter int X_W       = DEF_X_W,
   parameter int Y_W       = DEF_Y_W,
   parameter int SPRITE_W  = DEF_SPRITE_W,
   parameter int SPRITE_H  = DEF_SPRITE_H,
   parameter int DXY_W     = DEF_DXY_W,
   parameter int FRAME_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vsync,
   input  logic             write_xy,
   input  logic [X_W-1:0]   x_in,
   input  logic [Y_W-1:0]   y_in,
   input  logic             write_dxy,
   input  logic [DXY_W-1:0] dx_in,
   input  logic [DXY_W-1:0] dy_in,
   input  logic             enable_update,
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic             within_screen,
   output logic             moving
);
   localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - SPRITE_W);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - SPRITE_H);

   sprite_state_t    state, state_next;
   logic [DXY_W-1:0] dx, dy;
   logic [X_W-1:0]   x_next;
   logic [Y_W-1:0]   y_next;
   logic             on_next;
   logic             step;
   logic             step_apply;

   game_frame_tick #(.FRAME_DIV(FRAME_DIV)) u_frame_tick (
      .clk    (clk),
      .rst    (rst),
      .vsync  (vsync),
      .enable (enable_update),
      .clear  (write_xy),
      .step   (step)
   );

   // A position load always wins over a coincident step.
   always_comb begin
      step_apply = step && (state == MOVING) && !write_xy;
      x_next     = x;
      y_next     = y;
      if (write_xy) begin
         x_next = x_in;
         y_next = y_in;
      end else if (step_apply) begin
         x_next = x + {{(X_W-DXY_W){dx[DXY_W-1]}}, dx};
         y_next = y + {{(Y_W-DXY_W){dy[DXY_W-1]}}, dy};
      end
      on_next = (x_next <= X_MAX) && (y_next <= Y_MAX);

      state_next = state;
      if (write_xy) begin
         if (!on_next)           state_next = EXITED;
         else if (enable_update) state_next = MOVING;
         else                    state_next = STOPPED;
      end else begin
         case (state)
            STOPPED: if (enable_update && within_screen) state_next = MOVING;
            MOVING: begin
               if (!enable_update)             state_next = STOPPED;
               else if (step_apply && !on_next) state_next = EXITED;
            end
            EXITED:  state_next = EXITED;
            default: state_next = STOPPED;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= STOPPED;
         x             <= '0;
         y             <= '0;
         dx            <= '0;
         dy            <= '0;
         within_screen <= 1'b1;
      end else begin
         state         <= state_next;
         x             <= x_next;
         y             <= y_next;
         within_screen <= on_next;
         if (write_dxy) begin
            dx <= dx_in;
            dy <= dy_in;
         end
      end
   end

   assign moving = (state == MOVING);
endmodule

// File: tb/tb_game_sprite_motion_engine.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// behavioural integer model of the sprite's motion rules.
module tb_game_sprite_motion_engine;
   localparam int FD = 2;
   localparam int XM = 640 - 8;
   localparam int YM = 480 - 8;
   localparam int ST_STOP = 0, ST_MOVE = 1, ST_EXIT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync = 1'b0;
   logic       write_xy = 1'b0;
   logic [9:0] x_in = '0;
   logic [9:0] y_in = '0;
   logic       write_dxy = 1'b0;
   logic [3:0] dx_in = '0;
   logic [3:0] dy_in = '0;
   logic       enable_update = 1'b0;
   logic [9:0] x, y;
   logic       within_screen, moving;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   game_sprite_motion_engine dut (
      .clk(clk), .rst(rst), .vsync(vsync),
      .write_xy(write_xy), .x_in(x_in), .y_in(y_in),
      .write_dxy(write_dxy), .dx_in(dx_in), .dy_in(dy_in),
      .enable_update(enable_update),
      .x(x), .y(y), .within_screen(within_screen), .moving(moving)
   );

   // Behavioural model: plain integers, positions kept modulo 1024.
   int m_x, m_y, m_dx, m_dy, m_cnt, m_st;
   int m_ws, m_vprev;
   int n_x, n_y, n_cnt, n_st, n_ws;
   int stepping;

   always @* begin
      n_cnt    = m_cnt;
      stepping = 0;
      if (write_xy) n_cnt = 0;
      else if (vsync && !m_vprev && enable_update) begin
         if (m_cnt == FD - 1) begin
            n_cnt    = 0;
            stepping = (m_st == ST_MOVE);
         end else n_cnt = m_cnt + 1;
      end
      n_x = m_x;
      n_y = m_y;
      if (write_xy) begin
         n_x = int'(x_in);
         n_y = int'(y_in);
      end else if (stepping != 0) begin
         n_x = (m_x + m_dx + 1024) % 1024;
         n_y = (m_y + m_dy + 1024) % 1024;
      end
      n_ws = (n_x <= XM && n_y <= YM) ? 1 : 0;
      n_st = m_st;
      if (write_xy)
         n_st = (n_ws == 0) ? ST_EXIT : (enable_update ? ST_MOVE : ST_STOP);
      else if (m_st == ST_STOP && enable_update && m_ws == 1)
         n_st = ST_MOVE;
      else if (m_st == ST_MOVE && !enable_update)
         n_st = ST_STOP;
      else if (m_st == ST_MOVE && stepping != 0 && n_ws == 0)
         n_st = ST_EXIT;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_x <= 0; m_y <= 0; m_dx <= 0; m_dy <= 0; m_cnt <= 0;
         m_st <= ST_STOP; m_ws <= 1; m_vprev <= 0;
      end else begin
         m_x <= n_x; m_y <= n_y; m_cnt <= n_cnt; m_st <= n_st; m_ws <= n_ws;
         m_vprev <= int'(vsync);
         if (write_dxy) begin
            m_dx <= int'($signed(dx_in));
            m_dy <= int'($signed(dy_in));
         end
      end
   end

   always @(negedge clk) begin
      vectors++;
      if (int'(x) != m_x || int'(y) != m_y || int'(within_screen) != m_ws ||
          int'(moving) != ((m_st == ST_MOVE) ? 1 : 0)) begin
         miscompares++;
         $display("FAIL cycle t=%0t: x=%0d y=%0d ws=%0d mv=%0d required x=%0d y=%0d ws=%0d mv=%0d",
                  $time, x, y, within_screen, moving, m_x, m_y, m_ws, (m_st == ST_MOVE));
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d required %0d", nm, act, req);
      end else
         $display("check %s: %0d", nm, act);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic vedge();
      vsync = 1'b1; cyc(2);
      vsync = 1'b0; cyc(2);
   endtask

   task automatic load(input int xi, input int yi, input logic [3:0] dxv, input logic [3:0] dyv);
      write_xy = 1'b1; x_in = 10'(xi); y_in = 10'(yi);
      write_dxy = 1'b1; dx_in = dxv; dy_in = dyv;
      cyc(1);
      write_xy = 1'b0; write_dxy = 1'b0;
   endtask

   initial begin
      cyc(3);
      rst = 1'b0;
      #2 chk("reset_x", int'(x), 0);
      chk("reset_ws", int'(within_screen), 1);
      chk("reset_moving", int'(moving), 0);
      cyc(1);

      // Two steps over four frames at FRAME_DIV=2
      enable_update = 1'b1;
      load(100, 200, 4'd3, 4'hE);
      repeat (4) vedge();
      #2 chk("t2_x", int'(x), 106);
      chk("t2_y", int'(y), 196);
      chk("t2_moving", int'(moving), 1);
      cyc(1);

      // Right-edge exit
      load(630, 100, 4'd3, 4'd0);
      repeat (2) vedge();
      #2 chk("t3_x", int'(x), 633);
      chk("t3_ws", int'(within_screen), 0);
      chk("t3_moving", int'(moving), 0);
      cyc(1);
      repeat (2) vedge();
      #2 chk("t3_frozen_x", int'(x), 633);
      cyc(1);

      // Left wrap, then reload from EXITED
      load(1, 100, 4'hE, 4'd0);
      repeat (2) vedge();
      #2 chk("t4_wrap_x", int'(x), 1023);
      chk("t4_ws", int'(within_screen), 0);
      cyc(1);
      write_xy = 1'b1; x_in = 10'd50; y_in = 10'd50;
      cyc(1);
      write_xy = 1'b0;
      #2 chk("t4_reload_x", int'(x), 50);
      chk("t4_reload_ws", int'(within_screen), 1);
      chk("t4_reload_moving", int'(moving), 1);
      cyc(1);

      // Velocity load coincident with a step uses the old velocity
      load(10, 100, 4'd1, 4'd0);
      vedge();
      vsync = 1'b1; write_dxy = 1'b1; dx_in = 4'd5; dy_in = 4'd0;
      cyc(1);
      write_dxy = 1'b0; cyc(1);
      vsync = 1'b0; cyc(2);
      #2 chk("t5_old_dx", int'(x), 11);
      cyc(1);
      repeat (2) vedge();
      #2 chk("t5_new_dx", int'(x), 16);
      cyc(1);

      // Position load beats a coincident step and restarts the divider
      vedge();
      vsync = 1'b1; write_xy = 1'b1; x_in = 10'd40; y_in = 10'd100;
      cyc(1);
      write_xy = 1'b0; cyc(1);
      vsync = 1'b0; cyc(2);
      #2 chk("t6_drop", int'(x), 40);
      cyc(1);
      vedge();
      #2 chk("t6_no_step_yet", int'(x), 40);
      cyc(1);
      vedge();
      #2 chk("t6_step", int'(x), 45);
      cyc(1);

      // Asynchronous reset mid-motion
      vedge();
      #2 rst = 1'b1;
      #1 chk("t1_rst_x", int'(x), 0);
      chk("t1_rst_ws", int'(within_screen), 1);
      chk("t1_rst_moving", int'(moving), 0);
      enable_update = 1'b0;
      cyc(2);
      rst = 1'b0;
      repeat (2) vedge();
      #2 chk("t1_idle_x", int'(x), 0);
      chk("t1_idle_moving", int'(moving), 0);
      cyc(1);

      // Randomized traffic
      enable_update = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         write_xy = 1'b0; write_dxy = 1'b0;
         if ($urandom_range(0, 2) == 0) vsync = ~vsync;
         if ($urandom_range(0, 39) == 0) enable_update = ~enable_update;
         if ($urandom_range(0, 59) == 0) begin
            write_xy = 1'b1;
            x_in = 10'($urandom_range(0, 700));
            y_in = 10'($urandom_range(0, 520));
         end
         if ($urandom_range(0, 49) == 0) begin
            write_dxy = 1'b1;
            dx_in = 4'($urandom);
            dy_in = 4'($urandom);
         end
         cyc(1);
      end
      write_xy = 1'b0; write_dxy = 1'b0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
